// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin arbiter with a one-entry output buffer.
package rr_arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

   localparam int CNT_W = 16;

   // Increments a grant counter, holding at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first asserted request strictly after 'last', modulo N.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         winner,
   output logic [$clog2(N)-1:0] index,
   output logic                 any
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] pos;

   always_comb begin
      winner = '0;
      index  = '0;
      any    = 1'b0;
      pos    = '0;
      // NOTE: blocking assignments are required here; each iteration reads 'any' as set by earlier ones.
      for (int k = 1; k <= N; k++) begin
         pos = IW'((int'(last) + k) % N);
         if (!any && req[pos]) begin
            winner[pos] = 1'b1;
            index       = pos;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter feeding a one-entry output buffer toward a shared sink.
// Define RR_ARB_STATS_EN to add per-requester saturating accept counters on grant_cnt.
module rr_arb_ctrl
   import rr_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(N_REQ)-1:0] out_src,
   output logic [63:0]              cycles
`ifdef RR_ARB_STATS_EN
   ,
   output logic [N_REQ*CNT_W-1:0]   grant_cnt
`endif
);

   localparam int IDX_W = $clog2(N_REQ);

   buf_state_e        state_q;
   logic [DATA_W-1:0] out_data_q;
   logic [IDX_W-1:0]  out_src_q;
   logic [IDX_W-1:0]  last_grant_q;
   logic [63:0]       cycles_q;
   logic [63:0]       cycles_d;

   logic [N_REQ-1:0]  pick_winner;
   logic [IDX_W-1:0]  pick_index;
   logic              pick_any;
   logic              can_accept;
   logic              accept;
   logic [DATA_W-1:0] sel_data;

   rr_pick #(
      .N (N_REQ)
   ) u_pick (
      .req    (req_valid),
      .last   (last_grant_q),
      .winner (pick_winner),
      .index  (pick_index),
      .any    (pick_any)
   );

   assign can_accept = (state_q == EMPTY) || out_ready;

   // Qualifying with reset keeps any handshake from completing while reset is held low.
   assign req_ready  = pick_winner & {N_REQ{can_accept & reset}};
   assign accept     = pick_any & can_accept & reset;
   assign sel_data   = req_data[pick_index*DATA_W +: DATA_W];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= EMPTY;
         out_data_q   <= '0;
         out_src_q    <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
      end else begin
         if (accept) begin
            out_data_q   <= sel_data;
            out_src_q    <= pick_index;
            last_grant_q <= pick_index;
         end
         case (state_q)
            EMPTY:   if (accept) state_q <= FULL;
            FULL:    if (!accept && out_ready) state_q <= EMPTY;
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

   assign cycles_d = cycles_q + 64'd1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cycles_q <= '0;
      else        cycles_q <= cycles_d;
   end

   assign cycles = cycles_q;

`ifdef RR_ARB_STATS_EN
   logic [CNT_W-1:0] grant_cnt_q [N_REQ];

   // NOTE: this array is a small bank of flops, not RAM, so every entry is cleared on reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
      end else if (accept) begin
         grant_cnt_q[pick_index] <= sat_inc(grant_cnt_q[pick_index]);
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < N_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = grant_cnt_q[i];
   end
`endif

endmodule

// File: doc/rr_arb_ctrl.md
RR_ARB_CTRL -- requirements
Module: rr_arb_ctrl

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, payload width.
REQ-003 The block SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  N_REQ  per-requester valid.
REQ-006 The block SHALL have port req_data  input  N_REQ*DATA_W  per-requester payload; requester i in slice i.
REQ-007 The block SHALL have port req_ready  output  N_REQ  per-requester ready, combinational, one-hot or zero.
REQ-008 The block SHALL have port out_valid  output  1  buffered payload valid toward shared sink.
REQ-009 The block SHALL have port out_ready  input  1  sink ready.
REQ-010 The block SHALL have port out_data  output  DATA_W  buffered payload.
REQ-011 The block SHALL have port out_src  output  $clog2(N_REQ)  index of the requester that supplied out_data.
REQ-012 The block SHALL have port cycles  output  64  free-running cycle count since reset release.

Function
REQ-013 The block SHALL hold a one-entry output buffer with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 The block SHALL have a can_accept term equal to (state==EMPTY) or (out_ready==1).
REQ-015 The winner SHALL be the first asserted req_valid at or after index last_grant+1, modulo N_REQ.
REQ-016 req_ready[winner] SHALL be 1 only when can_accept is 1; all other req_ready bits SHALL be 0.
REQ-017 An accept (req_valid & req_ready) SHALL load out_data/out_src, set last_grant=winner and leave state FULL on the next edge (latency 1 cycle).
REQ-018 In FULL with out_ready=1 and no accept, state SHALL go to EMPTY; with accept, FULL SHALL persist with new data (back-to-back, 1 transfer/cycle).
REQ-019 In FULL with out_ready=0, out_data/out_src SHALL hold stable and all req_ready SHALL be 0.
REQ-020 With no req_valid, last_grant SHALL not change.
REQ-021 cycles SHALL increment by 1 every cycle and wrap from 2^64-1 to 0.

Reset
REQ-022 Asserting reset SHALL immediately force state EMPTY, out_valid=0, out_data=0, out_src=0, cycles=0, last_grant=N_REQ-1 (requester 0 first).
REQ-023 A buffered, undelivered payload SHALL be discarded on reset, including mid-transfer.
REQ-024 No accept SHALL occur while reset is low.

Configuration
REQ-025 With RR_ARB_STATS_EN defined, the block SHALL add output grant_cnt  N_REQ*16, per-requester accept counters, 0 on reset, saturating at 16'hFFFF.
REQ-026 Without RR_ARB_STATS_EN, grant_cnt and its counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package rr_arb_pkg SHALL hold the state enum (EMPTY, FULL) and the counter width constant (16).
REQ-028 The rotating-priority winner selection SHALL be a sub-module rr_pick (inputs req, last; output onehot winner, index, any).

Verification
REQ-029 Reset release, req_valid=4'b1111, out_ready=1 held -> accepts in order 0,1,2,3,0; out_valid high from cycle 1 onward, one transfer per cycle.
REQ-030 Only requester 2 valid with data 8'hA5, out_ready=0 for 3 cycles -> out_data=8'hA5, out_src=2 stable; req_ready=0 while stalled; delivered on first out_ready=1.
REQ-031 last_grant=1, req_valid=4'b1001 -> requester 3 wins before 0.
REQ-032 reset pulsed low while FULL and out_ready=0 -> out_valid=0, cycles=0 immediately (asynchronously); next grant goes to requester 0.
REQ-033 With RR_ARB_STATS_EN, requester 1 alone granted 70000 times -> grant_cnt[1]=16'hFFFF, others 0.
REQ-034 Run 20 cycles after reset release -> cycles=20; no req_valid -> out_valid stays 0, last_grant unchanged.
